// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode constants, register sentinel, instruction length rules.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package y86_pkg;

  // Instruction codes (upper nibble of byte0)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register field value meaning "no register"
  localparam logic [3:0] REG_NONE = 4'hF;

  // Longest encoding: byte0 + byte1 + 8 bytes of valC
  localparam int MAX_LEN  = 10;
  localparam int BUF_W    = MAX_LEN * 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_t;

  // One decoded instruction as it arrives on the input side
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
  } instr_t;

  typedef struct packed {
    logic [3:0] len;
    logic       valid;
  } len_info_t;

  // icodes that carry the {rA,rB} byte
  function automatic logic need_regids(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      default:                need_regids = 1'b0;
    endcase
  endfunction

  // icodes that carry an 8-byte constant
  function automatic logic need_valc(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_JXX, I_CALL: need_valc = 1'b1;
      default:       need_valc = 1'b0;
    endcase
  endfunction

  // Encoded length in bytes; same rules fetch uses to compute valP
  function automatic len_info_t instr_len(input logic [3:0] icode);
    len_info_t r;
    r.valid = (icode <= I_POPQ);
    r.len   = 4'd1;
    if (need_regids(icode)) r.len = r.len + 4'd1;
    if (need_valc(icode))   r.len = r.len + 4'd8;
    if (!r.valid)           r.len = 4'd0;
    instr_len = r;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> encoded byte length plus validity flag.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows icode.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid
);

  len_info_t info;

  // Length lookup shared with the fetch-side decoder rules
  always_comb begin
    info  = instr_len(icode);
    len   = info.len;
    valid = info.valid;
  end

endmodule

// File: rtl/y86_instr_writer.sv
// Serialises one decoded Y86-64 instruction into its byte stream and writes it to memory.
// Latency: accept cycle + len write cycles with mem_ready high; done pulses the cycle after the last byte.
// Backpressure: in_ready low while writing; mem_ready low freezes the current byte/address.
module y86_instr_writer
  import y86_pkg::*;
#(
  parameter int                  ADDR_W     = 64,
  parameter logic [ADDR_W-1:0]   RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              instr_error
);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [3:0]        idx_q;
  logic [3:0]        len_q;
  logic [BUF_W-1:0]  buf_q;
  logic [BUF_W-1:0]  buf_d;
  logic              done_q;
  logic              err_q;

  instr_t            in_instr;
  logic [3:0]        in_len;
  logic              in_len_valid;
  logic              accept;
  logic              start;
  logic              step;
  logic              last;

  assign in_instr = '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC};

  y86_instr_len u_len (
    .icode (in_instr.icode),
    .len   (in_len),
    .valid (in_len_valid)
  );

  // Byte image of the incoming instruction: byte0, optional {rA,rB}, then valC LSB first.
  // Bytes beyond the instruction length are never written, so their contents are don't-care.
  always_comb begin
    buf_d = '0;
    if (need_regids(in_instr.icode)) begin
      buf_d = {in_instr.valc, in_instr.ra, in_instr.rb, in_instr.icode, in_instr.ifun};
    end else begin
      buf_d = {8'h00, in_instr.valc, in_instr.icode, in_instr.ifun};
    end
  end

  // Next-state and handshake decode; addr_load blocks acceptance only while idle
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    accept   = 1'b0;
    start    = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !addr_load;
        accept   = in_valid && !addr_load;
        start    = accept && in_len_valid;
        if (start) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        step   = mem_ready;
        last   = (idx_q == len_q - 4'd1);
        if (step && last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Write pointer: explicit load while idle, otherwise advance once per accepted byte (wraps)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= RESET_ADDR;
    end else if (state_q == S_IDLE && addr_load) begin
      wr_ptr_q <= base_addr;
    end else if (step) begin
      wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
    end
  end

  // Byte index into the buffer; restarts on every accepted instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (start) begin
      idx_q <= '0;
    end else if (step) begin
      idx_q <= idx_q + 4'd1;
    end
  end

  // Capture the instruction image and length so inputs may change after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      len_q <= '0;
    end else if (start) begin
      buf_q <= buf_d;
      len_q <= in_len;
    end
  end

  // Registered single-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= step && last;
      err_q  <= accept && !in_len_valid;
    end
  end

  assign mem_addr    = wr_ptr_q;
  assign mem_wdata   = buf_q[{idx_q, 3'b000} +: 8];
  assign wr_ptr      = wr_ptr_q;
  assign done        = done_q;
  assign instr_error = err_q;

endmodule

// File: tb/tb_y86_instr_writer.sv
// Directed bench for the Y86-64 instruction writer: vector table plus hand sequences.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
// Memory writes are logged on the falling edge when mem_we and mem_ready are both high.
module tb_y86_instr_writer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        addr_load;
  logic [63:0] base_addr;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic [63:0] wr_ptr;
  logic        done;
  logic        instr_error;

  int checks = 0;
  int errors = 0;

  logic [63:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;

  y86_instr_writer #(.ADDR_W(64), .RESET_ADDR(64'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .addr_load   (addr_load),
    .base_addr   (base_addr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .wr_ptr      (wr_ptr),
    .done        (done),
    .instr_error (instr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model / event monitor
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (done)        done_cnt++;
    if (instr_error) err_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic go_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ptr(input logic [63:0] base);
    addr_load = 1'b1;
    base_addr = base;
    go_edge();
    addr_load = 1'b0;
    base_addr = 64'hDEAD_0000_0000_BEEF;
  endtask

  // Present one instruction for a single cycle, then scramble the fields
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
    go_edge();
    in_valid = 1'b0;
    icode = 4'h5; ifun = 4'hA; rA = 4'h5; rB = 4'hA; valC = 64'hA5A5_A5A5_A5A5_A5A5;
  endtask

  // Wait for done or instr_error counters to move; bounded
  task automatic wait_event(input int d0, input int e0, input int target_d, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      if ((done_cnt - d0) >= target_d || err_cnt != e0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for done/instr_error", name);
    end
  endtask

  typedef struct {
    bit          do_load;
    logic [63:0] base;
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc;
    int          len;
    logic [79:0] bytes;   // expected stream, byte0 in [7:0]
    bit          is_err;
  } vec_t;

  vec_t vecs[11];

  logic [63:0] exp_ptr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; base_addr = '0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0; mem_ready = 1'b1;

    vecs[0]  = '{1, 64'h100, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 10, 80'h0123456789ABCDEFF230, 0};
    vecs[1]  = '{1, 64'h0,   4'h0, 4'h0, 4'hF, 4'hF, 64'h1111,             1, 80'h00, 0};
    vecs[2]  = '{0, 64'h0,   4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                1, 80'h90, 0};
    vecs[3]  = '{0, 64'h0,   4'h8, 4'h0, 4'hF, 4'hF, 64'h40,               9, 80'h00000000000000004080, 0};
    vecs[4]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 2, 80'h3461, 0};
    vecs[5]  = '{0, 64'h0,   4'hD, 4'h0, 4'h1, 4'h2, 64'h77,               0, 80'h0, 1};
    vecs[6]  = '{0, 64'h0,   4'h4, 4'h0, 4'h1, 4'h5, 64'h18,              10, 80'h00000000000000181540, 0};
    vecs[7]  = '{0, 64'h0,   4'h7, 4'h3, 4'hF, 4'hF, 64'hDEADBEEF00112233, 9, 80'h00DEADBEEF0011223373, 0};
    vecs[8]  = '{0, 64'h0,   4'hA, 4'h0, 4'h7, 4'hF, 64'h0,                2, 80'h7FA0, 0};
    vecs[9]  = '{0, 64'h0,   4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                1, 80'h10, 0};
    vecs[10] = '{0, 64'h0,   4'hF, 4'h0, 4'h0, 4'h0, 64'h0,                0, 80'h0, 1};

    // Reset state
    @(negedge clk);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_wr_ptr", wr_ptr, 64'h0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_instr_error", {63'd0, instr_error}, 64'd0);
    go_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    go_edge();

    // Vector table
    exp_ptr = 64'h0;
    for (int v = 0; v < 11; v++) begin
      int d0, e0;
      logic [79:0] eb;
      if (vecs[v].do_load) begin
        load_ptr(vecs[v].base);
        exp_ptr = vecs[v].base;
      end
      log_addr.delete();
      log_data.delete();
      d0 = done_cnt;
      e0 = err_cnt;
      send(vecs[v].ic, vecs[v].fn, vecs[v].ra, vecs[v].rb, vecs[v].vc);
      wait_event(d0, e0, 1, $sformatf("vec%0d_wait", v));
      repeat (2) go_edge();
      eb = vecs[v].bytes;
      chk($sformatf("vec%0d_nbytes", v), 64'(log_data.size()), 64'(vecs[v].len));
      if (log_data.size() == vecs[v].len) begin
        for (int i = 0; i < vecs[v].len; i++) begin
          chk($sformatf("vec%0d_byte%0d_data", v, i), {56'd0, log_data[i]}, {56'd0, eb[8*i +: 8]});
          chk($sformatf("vec%0d_byte%0d_addr", v, i), log_addr[i], exp_ptr + 64'(i));
        end
      end
      exp_ptr = exp_ptr + 64'(vecs[v].len);
      chk($sformatf("vec%0d_wr_ptr", v), wr_ptr, exp_ptr);
      chk($sformatf("vec%0d_done_cnt", v), 64'(done_cnt - d0), vecs[v].is_err ? 64'd0 : 64'd1);
      chk($sformatf("vec%0d_err_cnt", v), 64'(err_cnt - e0), vecs[v].is_err ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d_in_ready_idle", v), {63'd0, in_ready}, 64'd1);
    end

    // Back-to-back halt then ret at address 0
    begin
      int d0;
      load_ptr(64'h0);
      log_addr.delete(); log_data.delete();
      d0 = done_cnt;
      icode = 4'h0; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valC = '0; in_valid = 1'b1;
      go_edge();                       // halt accepted
      icode = 4'h9;                    // ret presented immediately; must wait one cycle
      @(negedge clk);
      chk("b2b_in_ready_busy", {63'd0, in_ready}, 64'd0);
      go_edge();
      @(negedge clk);
      chk("b2b_in_ready_idle", {63'd0, in_ready}, 64'd1);
      go_edge();                       // ret accepted
      in_valid = 1'b0;
      wait_event(d0, err_cnt, 2, "b2b_wait");
      repeat (2) go_edge();
      chk("b2b_nbytes", 64'(log_data.size()), 64'd2);
      if (log_data.size() == 2) begin
        chk("b2b_b0", {log_addr[0][55:0], log_data[0]}, {56'h0, 8'h00});
        chk("b2b_b1", {log_addr[1][55:0], log_data[1]}, {56'h1, 8'h90});
      end
      chk("b2b_wr_ptr", wr_ptr, 64'h2);
      chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);
    end

    // call with mem_ready low for 3 cycles at byte 2
    begin
      int d0;
      logic [79:0] eb;
      eb = 80'h00000000000000004080;
      load_ptr(64'h200);
      log_addr.delete(); log_data.delete();
      d0 = done_cnt;
      send(4'h8, 4'h0, 4'hF, 4'hF, 64'h40);  // returns after accept edge
      go_edge();                             // byte 0 written
      go_edge();                             // byte 1 written
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("stall%0d_we", k), {63'd0, mem_we}, 64'd1);
        chk($sformatf("stall%0d_addr", k), mem_addr, 64'h202);
        chk($sformatf("stall%0d_data", k), {56'd0, mem_wdata}, 64'h00);
        chk($sformatf("stall%0d_wr_ptr", k), wr_ptr, 64'h202);
        go_edge();
      end
      mem_ready = 1'b1;
      wait_event(d0, err_cnt, 1, "stall_wait");
      repeat (2) go_edge();
      chk("stall_nbytes", 64'(log_data.size()), 64'd9);
      if (log_data.size() == 9) begin
        for (int i = 0; i < 9; i++) begin
          chk($sformatf("stall_byte%0d", i), {log_addr[i][55:0], log_data[i]},
              {56'h200 + 56'(i), eb[8*i +: 8]});
        end
      end
      chk("stall_wr_ptr", wr_ptr, 64'h209);
    end

    // Reset during byte 4 of rmmovq
    begin
      load_ptr(64'h300);
      log_addr.delete(); log_data.delete();
      send(4'h4, 4'h0, 4'h1, 4'h5, 64'h1122334455667788);
      repeat (4) go_edge();                  // bytes 0..3 written, byte 4 presented
      chk("rstmid_we_before", {63'd0, mem_we}, 64'd1);
      chk("rstmid_addr_before", mem_addr, 64'h304);
      rst = 1'b1;
      #1;
      chk("rstmid_we_now", {63'd0, mem_we}, 64'd0);
      chk("rstmid_wr_ptr", wr_ptr, 64'h0);
      repeat (2) go_edge();
      rst = 1'b0;
      repeat (12) go_edge();
      chk("rstmid_nbytes", 64'(log_data.size()), 64'd4);
      chk("rstmid_wr_ptr_after", wr_ptr, 64'h0);
    end

    // addr_load and in_valid together while idle: load wins, nothing accepted
    begin
      int d0, e0;
      log_addr.delete(); log_data.delete();
      d0 = done_cnt; e0 = err_cnt;
      addr_load = 1'b1; base_addr = 64'h400;
      icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valC = '0; in_valid = 1'b1;
      @(negedge clk);
      chk("ld_in_ready", {63'd0, in_ready}, 64'd0);
      go_edge();
      addr_load = 1'b0; in_valid = 1'b0;
      repeat (5) go_edge();
      chk("ld_wr_ptr", wr_ptr, 64'h400);
      chk("ld_nbytes", 64'(log_data.size()), 64'd0);
      chk("ld_done_cnt", 64'(done_cnt - d0), 64'd0);
      chk("ld_err_cnt", 64'(err_cnt - e0), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_instr_writer.md
Name: y86_instr_writer

Overview:
- Encoder/writer counterpart of the fetch stage. Takes one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) per handshake.
- Serialises it into the canonical byte stream: byte0 = {icode,ifun}, byte1 = {rA,rB}, then valC little-endian.
- Writes the stream one byte per cycle into instruction memory at an auto-incrementing write pointer.
- Used by the program loader and test benches to build images that fetch later decodes.

Parameters:
- ADDR_W, 64, width of write pointer and memory address.
- RESET_ADDR, 64'h0, write-pointer value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  writer can accept an instruction.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A (0xF = none).
- rB  in  4  register B (0xF = none).
- valC  in  64  constant/displacement/destination.
- addr_load  in  1  load write pointer from base_addr.
- base_addr  in  ADDR_W  new write-pointer value.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- mem_ready  in  1  memory accepts the byte this cycle.
- wr_ptr  out  ADDR_W  current write pointer (address of the next instruction = valP of the last one written).
- done  out  1  one-cycle pulse when the last byte of an instruction is accepted.
- instr_error  out  1  one-cycle pulse when an invalid icode is accepted.

Behaviour:
- Reset (async, immediate): state = IDLE, wr_ptr = RESET_ADDR, byte index = 0. mem_we, done and instr_error = 0. in_ready = 1 once rst deasserts. A reset mid-write abandons the instruction; no further bytes are written.
- Length by icode: 0 halt, 1 nop, 9 ret = 1 byte. 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq = 2 bytes. 7 jXX, 8 call = 9 bytes (byte0 + valC). 3 irmovq, 4 rmmovq, 5 mrmovq = 10 bytes. C..F invalid.
- Byte order: 9-byte form is byte0 then valC[7:0]..valC[63:56]. 10-byte form is byte0, byte1, then valC LSB first. Fields are written unmodified; no register-field checking.
- FSM has two states, IDLE and WRITE.
- IDLE:
  - in_ready = !addr_load.
  - addr_load: wr_ptr <= base_addr. It takes priority over in_valid, and no instruction is accepted that cycle.
  - in_valid & in_ready with a valid icode: latch all fields and the length into an 80-bit byte buffer, index = 0, go to WRITE.
  - in_valid & in_ready with an invalid icode: instr_error = 1 next cycle, no write, wr_ptr unchanged, stay in IDLE.
- WRITE:
  - in_ready = 0.
  - mem_we = 1, mem_addr = wr_ptr, mem_wdata = buffer byte[index].
  - mem_ready = 0: hold all outputs stable.
  - mem_ready = 1: wr_ptr += 1 and index += 1. On the last byte (index == len-1), done = 1 next cycle and go to IDLE.
  - addr_load is ignored in WRITE.
- Latency: accept cycle + len write cycles when mem_ready is held high. Minimum one IDLE cycle between instructions.
- Pointer arithmetic is modulo 2^ADDR_W. A write at the all-ones address wraps to 0 with no error.
- Input fields may change after the accept cycle without effect.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - REG_NONE = 4'hF.
  - Instruction-length function shared with fetch's need_regids/need_valC logic.
- One sub-module, y86_instr_len: combinational icode -> {len[3:0], valid}.

Test Plan:
- addr_load base_addr=0x100, then irmovq (icode 3, ifun 0, rA F, rB 2, valC 0x0123456789ABCDEF) -> bytes 30 F2 EF CD AB 89 67 45 23 01 at 0x100..0x109; done pulse; wr_ptr=0x10A.
- halt then ret back-to-back -> byte 00 at 0x0, byte 90 at 0x1; wr_ptr=2; two done pulses.
- call (icode 8, valC 0x40) with mem_ready low for 3 cycles at byte 2 -> mem_addr/mem_wdata held stable; final bytes 80 40 00 00 00 00 00 00 00; 9 accepted writes.
- icode 0xD with in_valid -> instr_error pulse, mem_we never 1, wr_ptr unchanged, in_ready=1 next cycle.
- base_addr=0xFFFF_FFFF_FFFF_FFFF, OPq (icode 6, ifun 1, rA 3, rB 4) -> 61 at 0xFFFF_FFFF_FFFF_FFFF, 34 at 0x0; wr_ptr=1.
- rst asserted during byte 4 of rmmovq -> mem_we drops immediately, wr_ptr=RESET_ADDR, no further writes; addr_load+in_valid together in IDLE -> pointer loads, instruction not accepted.
